// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit for a single-cycle MIPS datapath: IDLE/FETCH/READY/FAULT sequencer.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_new,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    logic [31:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            FETCH: begin
                if (mem_ack) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = READY;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            READY: begin
                if (advance) begin
                    pc_d          = pc_new;
                    instr_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d         = '0;
`endif
                    if (pc_new[1:0] != 2'b00) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
        endcase

        // Request outputs are registered, so they follow the state being entered.
        mem_req_d  = (state_d == FETCH);
        mem_addr_d = mem_req_d ? pc_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit (timeout scenario follows FETCH_TIMEOUT_EN).
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_new = '0;
    logic        advance = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        fault;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mips_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_new     (pc_new),
        .advance    (advance),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        advance = 1'b0;
        mem_ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", mem_addr, 32'h0); end
        tick();
        reset = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_fetch_req: got %b expected 1", mem_req); end
    endtask

    task automatic test_min_latency();
        do_reset();
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lat_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL lat_addr: got %h expected %h", mem_addr, 32'h0); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h2008_0005;
        tick();
        mem_ack = 1'b0;
        checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL lat_instr: got %h expected %h", instr, 32'h2008_0005); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", instr_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lat_req_drop: got %b expected 0", mem_req); end
    endtask

    task automatic test_advance_wait();
        advance = 1'b1;
        pc_new  = 32'h0000_0040;
        tick();
        advance = 1'b0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL adv_pc: got %h expected %h", pc, 32'h40); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL adv_wait_valid[%0d]: got %b expected 0", i, instr_valid); end
            checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL adv_wait_addr[%0d]: got %h expected %h", i, mem_addr, 32'h40); end
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h8C09_0004;
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL adv_valid: got %b expected 1", instr_valid); end
        checks++; if (instr !== 32'h8C09_0004) begin errors++; $display("FAIL adv_instr: got %h expected %h", instr, 32'h8C09_0004); end
    endtask

    task automatic test_hold();
        advance = 1'b0;
        pc_new  = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            mem_ack   = i[0];
            mem_rdata = 32'hA5A5_0000 + i;
            tick();
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected %h", i, pc, 32'h40); end
            checks++; if (instr !== 32'h8C09_0004) begin errors++; $display("FAIL hold_instr[%0d]: got %h expected %h", i, instr, 32'h8C09_0004); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, instr_valid); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b expected 0", i, mem_req); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_self_loop();
        advance = 1'b1;
        pc_new  = 32'h0000_0040;
        tick();
        advance = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL loop_valid: got %b expected 0", instr_valid); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL loop_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL loop_addr: got %h expected %h", mem_addr, 32'h40); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1000_FFFF;
        tick();
        mem_ack = 1'b0;
        checks++; if (instr !== 32'h1000_FFFF) begin errors++; $display("FAIL loop_instr: got %h expected %h", instr, 32'h1000_FFFF); end
    endtask

    task automatic test_wrap();
        advance = 1'b1;
        pc_new  = 32'hFFFF_FFFC;
        tick();
        advance = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected %h", mem_addr, 32'hFFFF_FFFC); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b expected 0", fault); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_000C;
        tick();
        mem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", instr_valid); end
    endtask

    task automatic test_misaligned();
        advance = 1'b1;
        pc_new  = 32'h0000_0042;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", instr_valid); end
        checks++; if (pc !== 32'h42) begin errors++; $display("FAIL mis_pc: got %h expected %h", pc, 32'h42); end
        pc_new  = 32'h0000_0080;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h42) begin errors++; $display("FAIL mis_stuck_pc[%0d]: got %h expected %h", i, pc, 32'h42); end
            checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_stuck_fault[%0d]: got %b expected 1", i, fault); end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_stuck_req[%0d]: got %b expected 0", i, mem_req); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_stuck_valid[%0d]: got %b expected 0", i, instr_valid); end
        end
        advance = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_clears_fault: got %b expected 0", fault); end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        advance = 1'b1;
        pc_new  = 32'h0000_0100;
        tick();
        advance = 1'b0;
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rmf_pre_addr: got %h expected %h", mem_addr, 32'h100); end
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmf_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rmf_instr: got %h expected %h", instr, 32'h0); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmf_req: got %b expected 0", mem_req); end
        tick();
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rmf_ack_discard: got %h expected %h", instr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b expected 0", instr_valid); end
        reset   = 1'b0;
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmf_idle_req: got %b expected 0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmf_refetch_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rmf_refetch_addr: got %h expected %h", mem_addr, 32'h0); end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        mem_ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmo_early_fault[%0d]: got %b expected 0", i, fault); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo_early_req[%0d]: got %b expected 1", i, mem_req); end
            tick();
        end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL tmo_fault: got %b expected 1", fault); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tmo_req: got %b expected 0", mem_req); end
`else
        for (int i = 0; i < 100; i++) begin
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL notmo_fault[%0d]: got %b expected 0", i, fault); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL notmo_req[%0d]: got %b expected 1", i, mem_req); end
            tick();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_advance_wait();
        test_hold();
        test_self_loop();
        test_wrap();
        test_misaligned();
        test_reset_mid_fetch();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, maximum FETCH cycles without mem_ack; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_new  input  32  next PC from the single-cycle datapath.
REQ-006 advance  input  1  datapath has consumed the current instruction; load pc_new.
REQ-007 pc  output  32  registered current PC, driven to the datapath.
REQ-008 instr  output  32  registered fetched instruction word.
REQ-009 instr_valid  output  1  instr holds the word at address pc.
REQ-010 mem_req  output  1  instruction-memory read request.
REQ-011 mem_addr  output  32  instruction-memory read address.
REQ-012 mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-013 mem_rdata  input  32  instruction-memory read data.
REQ-014 fault  output  1  sticky error flag: misaligned PC or fetch timeout.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, READY and FAULT.
REQ-016 IDLE SHALL move to FETCH unconditionally on the next clock edge.
REQ-017 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; in every other state, mem_req SHALL be 0 and mem_addr SHALL be 0.
REQ-018 In FETCH with mem_ack=1 at an edge, the unit SHALL latch instr<=mem_rdata, set instr_valid<=1 and go to READY; without mem_ack it SHALL stay in FETCH.
REQ-019 Minimum latency: mem_ack in the first FETCH cycle N SHALL give instr_valid=1 in cycle N+1.
REQ-020 mem_ack outside FETCH SHALL be ignored, and mem_rdata SHALL be captured only under REQ-018.
REQ-021 In READY with advance=1: the unit SHALL set pc<=pc_new and instr_valid<=0; it SHALL go to FAULT if pc_new[1:0]!=0, otherwise to FETCH.
REQ-022 In READY with advance=0, pc, instr and instr_valid SHALL all hold.
REQ-023 advance in IDLE, FETCH or FAULT SHALL be ignored.
REQ-024 In FAULT, the unit SHALL hold fault=1, instr_valid=0 and mem_req=0, and SHALL leave FAULT only by reset.
REQ-025 pc_new == pc, a self-loop, SHALL be legal and SHALL re-fetch the same address.
REQ-026 pc arithmetic SHALL be 32-bit with no wrap checks; pc_new=32'hFFFF_FFFC SHALL be accepted.

Reset
REQ-027 Asserting reset SHALL immediately force pc=RESET_PC, instr=0, instr_valid=0, fault=0, state=IDLE, mem_req=0 and mem_addr=0.
REQ-028 Reset asserted mid-FETCH SHALL abandon the pending request, and an ack arriving during reset SHALL be discarded.
REQ-029 After reset deassertion, mem_req SHALL first assert in the second cycle, via IDLE.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN: when defined, a counter SHALL clear on entry to FETCH and count each FETCH cycle without mem_ack; at TIMEOUT such cycles the unit SHALL go to FAULT with fault=1.
REQ-031 When FETCH_TIMEOUT_EN is undefined, there SHALL be no counter, and FETCH SHALL wait for mem_ack indefinitely.

Verification
REQ-032 Reset release, mem_ack=1 in the first FETCH cycle with mem_rdata=32'h2008_0005 -> mem_addr=0, then next cycle instr=32'h2008_0005 and instr_valid=1.
REQ-033 READY, advance=1, pc_new=32'h0000_0040, ack after 3 wait cycles -> pc=0x40, instr_valid=0 for 4 cycles, then 1.
REQ-034 READY, advance=1, pc_new=32'h0000_0042 -> fault=1 next cycle, mem_req stays 0, and a later advance has no effect.
REQ-035 Reset pulse during FETCH with mem_ack=1 in the same cycle -> instr=0, instr_valid=0, pc=RESET_PC, and the fetch restarts via IDLE.
REQ-036 With FETCH_TIMEOUT_EN defined and TIMEOUT=4, mem_ack held 0 -> fault=1 after exactly 4 FETCH cycles; without the macro, fault stays 0 for 100 cycles.
REQ-037 READY with advance=0 for 10 cycles while mem_ack toggles -> pc, instr and instr_valid unchanged, mem_req=0.
